// File: rtl/wb_pkg.sv
// Shared types for the writeback stage and the upstream load/ALU merge.
//   wb_state_t : writeback handshake FSM states
//   grant_t    : which producer channel owns the current write
//   R_TYPE / I_TYPE_LD : opcode constants used by the merge stage
//   rr_pick    : round-robin choice between two pending channels
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } wb_state_t;

  typedef enum logic {
    GRANT_LD  = 1'b0,
    GRANT_ALU = 1'b1
  } grant_t;

  localparam logic [6:0] R_TYPE    = 7'b0110011;
  localparam logic [6:0] I_TYPE_LD = 7'b0000011;

  // With both channels pending, the one that did not win last time goes next.
  function automatic grant_t rr_pick(input logic pend_ld, input logic pend_alu,
                                     input grant_t last);
    if (pend_ld && pend_alu) return (last == GRANT_LD) ? GRANT_ALU : GRANT_LD;
    else if (pend_ld)        return GRANT_LD;
    else                     return GRANT_ALU;
  endfunction

endpackage

// File: rtl/req_sync.sv
// Multi-flop synchronizer for one asynchronous 4-phase request line.
//   clk     : destination clock
//   rst     : synchronous active-high reset, clears the whole chain
//   async_i : request from the self-timed producer
//   sync_o  : request after STAGES flops in the clk domain
module req_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], async_i};
  end

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= chain_d;
  end

  assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/wb_merge_sync.sv
// Writeback stage bridging the self-timed load and ALU result channels into
// the clocked register file. Each channel is a 4-phase bundled-data handshake;
// requests are synchronized, arbitrated round-robin, written for one cycle,
// then acknowledged until the producer withdraws its request.
//   clk, rst              : clock, synchronous active-high reset
//   req_ld/rd_ld/data_ld  : load channel request + bundled destination/data
//   ack_ld                : load channel acknowledge
//   req_alu/rd_alu/...    : ALU channel request + bundled destination/data
//   ack_alu               : ALU channel acknowledge
//   rf_we/rf_waddr/rf_wdata : register-file write port (rf_we is a 1-cycle pulse)
//   busy                  : high whenever the FSM is not IDLE
module wb_merge_sync
  import wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ld,
  input  logic [REG_AW-1:0] rd_ld,
  input  logic [DATA_W-1:0] data_ld,
  output logic              ack_ld,
  input  logic              req_alu,
  input  logic [REG_AW-1:0] rd_alu,
  input  logic [DATA_W-1:0] data_alu,
  output logic              ack_alu,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);

  logic req_ld_s;
  logic req_alu_s;

  req_sync #(.STAGES(SYNC_STAGES)) u_sync_ld (
    .clk     (clk),
    .rst     (rst),
    .async_i (req_ld),
    .sync_o  (req_ld_s)
  );

  req_sync #(.STAGES(SYNC_STAGES)) u_sync_alu (
    .clk     (clk),
    .rst     (rst),
    .async_i (req_alu),
    .sync_o  (req_alu_s)
  );

  wb_state_t         state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic              ack_ld_q, ack_ld_d;
  logic              ack_alu_q, ack_alu_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              busy_q, busy_d;

  logic   pend_ld;
  logic   pend_alu;
  grant_t pick;
  logic   gnt_req;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ack_ld_d     = ack_ld_q;
    ack_alu_d    = ack_alu_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;

    pend_ld  = req_ld_s  && !ack_ld_q;
    pend_alu = req_alu_s && !ack_alu_q;
    pick     = rr_pick(pend_ld, pend_alu, last_grant_q);
    // last_grant_q doubles as the owner of the in-flight handshake.
    gnt_req  = (last_grant_q == GRANT_LD) ? req_ld_s : req_alu_s;

    case (state_q)
      IDLE: begin
        if (pend_ld || pend_alu) begin
          last_grant_d = pick;
          if (pick == GRANT_LD) begin
            rf_waddr_d = rd_ld;
            rf_wdata_d = data_ld;
          end else begin
            rf_waddr_d = rd_alu;
            rf_wdata_d = data_alu;
          end
          // x0 is hardwired: skip the write but keep the handshake timing.
          rf_we_d = (rf_waddr_d != '0);
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d   = ACK;
        ack_ld_d  = (last_grant_q == GRANT_LD);
        ack_alu_d = (last_grant_q == GRANT_ALU);
      end
      ACK: begin
        if (!gnt_req) begin
          state_d   = RELEASE;
          ack_ld_d  = 1'b0;
          ack_alu_d = 1'b0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        ack_ld_d  = 1'b0;
        ack_alu_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_ALU;
      ack_ld_q     <= 1'b0;
      ack_alu_q    <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ack_ld_q     <= ack_ld_d;
      ack_alu_q    <= ack_alu_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign ack_ld   = ack_ld_q;
  assign ack_alu  = ack_alu_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_wb_merge_sync.sv
// Self-checking bench for wb_merge_sync: directed scenarios with literal
// expectations plus randomized two-producer traffic, all outputs compared
// every cycle against a transaction-timeline reference model.
module tb_wb_merge_sync;
  import wb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_ld = 1'b0, req_alu = 1'b0;
  logic [AW-1:0] rd_ld = '0, rd_alu = '0;
  logic [DW-1:0] data_ld = '0, data_alu = '0;
  logic          ack_ld, ack_alu, rf_we, busy;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_merge_sync #(.DATA_W(DW), .REG_AW(AW), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_ld   (req_ld),
    .rd_ld    (rd_ld),
    .data_ld  (data_ld),
    .ack_ld   (ack_ld),
    .req_alu  (req_alu),
    .rd_alu   (rd_alu),
    .data_alu (data_alu),
    .ack_alu  (ack_alu),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Requests become visible to arbitration S edges after they are sampled.
  // A transaction granted at edge g writes after g, acknowledges after g+1,
  // drops its ack at the first edge >= g+2 where the owner's visible request
  // is low (drop_e), and frees the arbiter one edge after that.
  logic          hl[S], ha[S];
  int            cyc = 0;
  bit            mvalid = 0;
  bit            inflight = 0;
  int            owner = 0, g_e = 0, drop_e = -1, last_g = 1;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          e_we = 0, e_ackl = 0, e_acka = 0, e_busy = 0;

  always @(posedge clk) begin : model
    logic vl, va, vo;
    cyc++;
    vl = hl[S-1];
    va = ha[S-1];
    for (int i = S-1; i > 0; i--) begin
      hl[i] = hl[i-1];
      ha[i] = ha[i-1];
    end
    hl[0] = req_ld;
    ha[0] = req_alu;
    if (rst) begin
      for (int i = 0; i < S; i++) begin hl[i] = 1'b0; ha[i] = 1'b0; end
      mvalid = 1; inflight = 0; last_g = 1; drop_e = -1;
      m_waddr = '0; m_wdata = '0;
    end else if (mvalid) begin
      vo = (owner == 0) ? vl : va;
      if (inflight && drop_e >= 0 && cyc == drop_e + 1) begin
        inflight = 0;
      end else if (inflight && drop_e < 0 && cyc >= g_e + 2 && !vo) begin
        drop_e = cyc;
      end else if (!inflight && (vl || va)) begin
        if (vl && va) owner = (last_g == 1) ? 0 : 1;
        else          owner = vl ? 0 : 1;
        last_g   = owner;
        inflight = 1;
        g_e      = cyc;
        drop_e   = -1;
        m_waddr  = (owner == 0) ? rd_ld : rd_alu;
        m_wdata  = (owner == 0) ? data_ld : data_alu;
      end
    end
    e_we   = inflight && cyc == g_e && m_waddr != '0;
    e_ackl = inflight && owner == 0 && cyc >= g_e + 1 && (drop_e < 0 || cyc < drop_e);
    e_acka = inflight && owner == 1 && cyc >= g_e + 1 && (drop_e < 0 || cyc < drop_e);
    e_busy = inflight;
  end

  // ---------------- compare + write log ----------------
  typedef struct {
    int            e_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t wlog[$];

  always @(negedge clk) begin
    if (mvalid) begin
      chk("rf_we",    rf_we,    e_we);
      chk("ack_ld",   ack_ld,   e_ackl);
      chk("ack_alu",  ack_alu,  e_acka);
      chk("busy",     busy,     e_busy);
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("two_acks", ack_ld & ack_alu, 0);
      chk("ack_with_we", (ack_ld | ack_alu) & rf_we, 0);
      chk("we_outside_write", rf_we && (dut.state_q != WRITE), 0);
      if (rf_we === 1'b1) wlog.push_back('{cyc, rf_waddr, rf_wdata});
    end
  end

  assert property (@(posedge clk) disable iff (rst) rf_we |-> (dut.state_q == WRITE))
    else $error("FAIL assert_we_in_write");

  // ---------------- producer agent ----------------
  function automatic logic ack_of(input int ch);
    return (ch == 0) ? ack_ld : ack_alu;
  endfunction

  task automatic set_req(input int ch, input logic v);
    if (ch == 0) req_ld = v; else req_alu = v;
  endtask

  // One full 4-phase transaction. ts: raise edge, ta: ack seen, td: drop edge, tf: ack low.
  task automatic txn(input int ch, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                     input int hold, output int ts, output int ta, output int td, output int tf);
    int n;
    @(posedge clk); #1;
    if (ch == 0) begin rd_ld = rd; data_ld = d; end
    else         begin rd_alu = rd; data_alu = d; end
    set_req(ch, 1'b1);
    ts = cyc;
    n = 0;
    while (!ack_of(ch) && n < 200) begin @(posedge clk); #1; n++; end
    if (!ack_of(ch)) chk("ack_rise_timeout", ack_of(ch), 1);
    ta = cyc;
    // bundled data only needs to hold until ack rises
    if (ch == 0) begin rd_ld = AW'($urandom); data_ld = $urandom; end
    else         begin rd_alu = AW'($urandom); data_alu = $urandom; end
    repeat (hold) begin @(posedge clk); #1; end
    set_req(ch, 1'b0);
    td = cyc;
    n = 0;
    while (ack_of(ch) && n < 50) begin @(posedge clk); #1; n++; end
    if (ack_of(ch)) chk("ack_fall_timeout", ack_of(ch), 0);
    tf = cyc;
  endtask

  task automatic agent(input int ch, input int cnt);
    int a, b, c, d;
    logic [AW-1:0] rd;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      rd = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom);
      txn(ch, rd, $urandom, $urandom_range(0, 3), a, b, c, d);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ts, ta, td, tf, n0, n, r_e;
    int ts2, ta2, td2, tf2;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // idle after reset
    repeat (20) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_we", rf_we, 0);
    chk("idle_acks", {ack_ld, ack_alu}, 0);
    chk("idle_waddr", rf_waddr, 0);

    // single load
    n0 = wlog.size();
    txn(0, 5'd5, 32'hDEADBEEF, 0, ts, ta, td, tf);
    chk("ld_write_count", wlog.size() - n0, 1);
    if (wlog.size() > n0) begin
      chk("ld_we_edge", wlog[n0].e_n - ts, 3);
      chk("ld_addr", wlog[n0].addr, 5);
      chk("ld_data", wlog[n0].data, 32'hDEADBEEF);
    end
    chk("ld_ack_edge", ta - ts, 4);
    chk("ld_ack_fall", tf - td, 3);

    // tie after reset: load wins, then ALU
    do_reset();
    n0 = wlog.size();
    fork
      txn(0, 5'd1, 32'h11, 0, ts, ta, td, tf);
      txn(1, 5'd2, 32'h22, 0, ts2, ta2, td2, tf2);
    join
    chk("tie1_count", wlog.size() - n0, 2);
    if (wlog.size() >= n0 + 2) begin
      chk("tie1_first_addr", wlog[n0].addr, 1);
      chk("tie1_first_data", wlog[n0].data, 32'h11);
      chk("tie1_second_addr", wlog[n0+1].addr, 2);
      chk("tie1_second_data", wlog[n0+1].data, 32'h22);
    end

    // a lone load makes the load channel the last winner, so the next tie goes to ALU
    txn(0, 5'd9, 32'h99, 0, ts, ta, td, tf);
    n0 = wlog.size();
    fork
      txn(0, 5'd3, 32'h33, 1, ts, ta, td, tf);
      txn(1, 5'd4, 32'h44, 1, ts2, ta2, td2, tf2);
    join
    chk("tie2_count", wlog.size() - n0, 2);
    if (wlog.size() >= n0 + 2) begin
      chk("tie2_first_addr", wlog[n0].addr, 4);
      chk("tie2_second_addr", wlog[n0+1].addr, 3);
    end

    // ALU write to x0: no write, same handshake timing
    n0 = wlog.size();
    txn(1, 5'd0, 32'hFFFF, 0, ts, ta, td, tf);
    chk("x0_no_write", wlog.size() - n0, 0);
    chk("x0_ack_edge", ta - ts, 4);
    chk("x0_ack_fall", tf - td, 3);

    // reset while acknowledging a load that is still requesting
    @(posedge clk); #1;
    rd_ld = 5'd7; data_ld = 32'h77; req_ld = 1'b1;
    n = 0;
    while (!ack_ld && n < 50) begin @(posedge clk); #1; n++; end
    chk("rst_pre_ack", ack_ld, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    r_e = cyc;
    chk("rst_ack_dropped", ack_ld, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    n0 = wlog.size();
    n = 0;
    while (wlog.size() == n0 && n < 50) begin @(negedge clk); n++; end
    chk("rst_rewrite_count", wlog.size() - n0, 1);
    if (wlog.size() > n0) begin
      chk("rst_rewrite_edge", wlog[n0].e_n - r_e, 3);
      chk("rst_rewrite_addr", wlog[n0].addr, 7);
      chk("rst_rewrite_data", wlog[n0].data, 32'h77);
    end
    @(posedge clk); #1;
    n = 0;
    while (!ack_ld && n < 50) begin @(posedge clk); #1; n++; end
    req_ld = 1'b0;
    n = 0;
    while (ack_ld && n < 50) begin @(posedge clk); #1; n++; end
    chk("rst_final_ack_low", ack_ld, 0);

    // ALU burst of four
    n0 = wlog.size();
    for (int i = 0; i < 4; i++) txn(1, AW'(8 + i), 32'hA0 + i, 0, ts, ta, td, tf);
    chk("burst_count", wlog.size() - n0, 4);
    for (int i = 0; i < 4; i++)
      if (wlog.size() > n0 + i) begin
        chk("burst_addr", wlog[n0+i].addr, 8 + i);
        chk("burst_data", wlog[n0+i].data, 32'hA0 + i);
      end

    // random concurrent traffic
    fork
      agent(0, 15);
      agent(1, 15);
    join

    repeat (10) @(posedge clk);
    #1;
    chk("end_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
